// File: rtl/baud_tick_counter.sv
// Programmable prescaler feeding a WIDTH-bit up/down wrap/saturate counter; optional capture via BTC_CAPTURE_EN.
// Latency: count/tick/tc registered, one cycle after the step edge; no backpressure (en only freezes state).
module baud_tick_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      modulo,
  input  logic                  dir,
  input  logic                  mode,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  capture,
  output logic [WIDTH-1:0]      count,
  output logic                  tick,
  output logic                  tc,
  output logic                  sat,
  output logic [WIDTH-1:0]      cap_val,
  output logic                  cap_valid
);

  logic [PRESCALE_W-1:0] pcnt;
  logic                  step;
  logic [WIDTH-1:0]      next_count;
  logic                  next_tc;

  assign step = en && (pcnt == prescale);

  // Bounds are tested before +/-1, so out-of-range counts are pulled back and nothing overflows.
  always_comb begin
    next_count = count;
    next_tc    = 1'b0;
    case ({dir, mode})
      2'b00: begin
        if (count >= modulo) begin
          next_count = '0;
          next_tc    = 1'b1;
        end else begin
          next_count = count + 1'b1;
        end
      end
      2'b01: begin
        if (count >= modulo) begin
          next_count = modulo;
        end else begin
          next_count = count + 1'b1;
          next_tc    = ((count + 1'b1) == modulo);
        end
      end
      2'b10: begin
        if (count == '0) begin
          next_count = modulo;
          next_tc    = 1'b1;
        end else if (count > modulo) begin
          next_count = modulo;
        end else begin
          next_count = count - 1'b1;
        end
      end
      default: begin
        if (count == '0) begin
          next_count = '0;
        end else if (count == WIDTH'(1)) begin
          next_count = '0;
          next_tc    = 1'b1;
        end else if (count > modulo) begin
          next_count = modulo;
        end else begin
          next_count = count - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      pcnt  <= '0;
      tick  <= 1'b0;
      tc    <= 1'b0;
    end else begin
      tick <= 1'b0;
      tc   <= 1'b0;
      if (load) begin
        // A load swallows any coincident step and restarts the prescaler.
        count <= load_val;
        pcnt  <= '0;
      end else if (step) begin
        count <= next_count;
        pcnt  <= '0;
        tick  <= 1'b1;
        tc    <= next_tc;
      end else if (en) begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

  assign sat = mode && (dir ? (count == '0) : (count >= modulo));

`ifdef BTC_CAPTURE_EN
  // Capture samples the pre-update count and wins over a same-cycle load.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_val   <= '0;
      cap_valid <= 1'b0;
    end else if (capture) begin
      cap_val   <= count;
      cap_valid <= 1'b1;
    end else if (load) begin
      cap_valid <= 1'b0;
    end
  end
`else
  logic unused_capture;
  assign unused_capture = capture;
  assign cap_val        = '0;
  assign cap_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_baud_tick_counter.sv
// Bench for baud_tick_counter: directed scenarios plus randomized traffic against an integer reference model.
module tb_baud_tick_counter;

  localparam int WIDTH = 8;
  localparam int PW    = 16;

  logic             clk = 1'b0;
  logic             rst, en, dir, mode, load, capture;
  logic [PW-1:0]    prescale;
  logic [WIDTH-1:0] modulo, load_val;
  logic [WIDTH-1:0] count, cap_val;
  logic             tick, tc, sat, cap_valid;

  int n_checks = 0;
  int n_fail   = 0;

  int   m_count, m_pcnt, m_cap_val;
  logic m_tick, m_tc, m_cap_valid;

  always #5 clk = ~clk;

  baud_tick_counter #(.WIDTH(WIDTH), .PRESCALE_W(PW)) dut (
    .clk(clk), .rst(rst), .en(en), .prescale(prescale), .modulo(modulo),
    .dir(dir), .mode(mode), .load(load), .load_val(load_val), .capture(capture),
    .count(count), .tick(tick), .tc(tc), .sat(sat),
    .cap_val(cap_val), .cap_valid(cap_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Counting rules for one step, straight from the mode table.
  function automatic void next_rule(input int c, input int m, input logic d, input logic s,
                                    output int n, output logic t);
    t = 1'b0;
    if (!d) begin
      if (c >= m) begin
        n = s ? m : 0;
        t = !s;
      end else begin
        n = c + 1;
        t = s && (n == m);
      end
    end else begin
      if (c == 0) begin
        n = s ? 0 : m;
        t = !s;
      end else if (s && c == 1) begin
        n = 0;
        t = 1'b1;
      end else if (c > m) begin
        n = m;
      end else begin
        n = c - 1;
      end
    end
  endfunction

  task automatic model_update();
    int   nc;
    logic ntc;
    int   old;
    if (rst) begin
      m_count = 0; m_pcnt = 0; m_tick = 0; m_tc = 0; m_cap_val = 0; m_cap_valid = 0;
    end else begin
      old = m_count;
`ifdef BTC_CAPTURE_EN
      if (capture) begin
        m_cap_val   = old;
        m_cap_valid = 1'b1;
      end else if (load) begin
        m_cap_valid = 1'b0;
      end
`endif
      m_tick = 1'b0;
      m_tc   = 1'b0;
      if (load) begin
        m_count = int'(load_val);
        m_pcnt  = 0;
      end else if (en && m_pcnt == int'(prescale)) begin
        next_rule(old, int'(modulo), dir, mode, nc, ntc);
        m_count = nc;
        m_tc    = ntc;
        m_tick  = 1'b1;
        m_pcnt  = 0;
      end else if (en) begin
        m_pcnt = (m_pcnt + 1) % (1 << PW);
      end
    end
  endtask

  task automatic check_outputs();
    logic exp_sat;
    exp_sat = mode && (dir ? (m_count == 0) : (m_count >= int'(modulo)));
    chk("count", 32'(count), m_count);
    chk("tick", 32'(tick), 32'(m_tick));
    chk("tc", 32'(tc), 32'(m_tc));
    chk("sat", 32'(sat), 32'(exp_sat));
    chk("cap_val", 32'(cap_val), m_cap_val);
    chk("cap_valid", 32'(cap_valid), 32'(m_cap_valid));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    check_outputs();
  endtask

  initial begin
    int exp_dn[4];
    exp_dn = '{1, 0, 9, 8};
    m_count = 0; m_pcnt = 0; m_tick = 0; m_tc = 0; m_cap_val = 0; m_cap_valid = 0;
    rst = 1'b1; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; capture = 1'b0;
    prescale = '0; modulo = '0; load_val = '0;
    #1;
    cycle();
    cycle();
    chk("rst_count", 32'(count), 0);
    chk("rst_tick", 32'(tick), 0);

    // Wrap up, prescale 3: a step every 4th enabled cycle.
    rst = 1'b0; en = 1'b1; prescale = 16'd3; modulo = 8'd5;
    for (int i = 1; i <= 32; i++) begin
      cycle();
      chk("wrap_tick", 32'(tick), (i % 4 == 0) ? 1 : 0);
      chk("wrap_tc", 32'(tc), (i == 24) ? 1 : 0);
      if (i == 20) chk("wrap_c20", 32'(count), 5);
      if (i == 24) chk("wrap_c24", 32'(count), 0);
    end

    // Reset mid-run at count 7.
    prescale = '0; modulo = 8'd20;
    for (int i = 0; i < 40 && m_count != 7; i++) cycle();
    chk("reach7", 32'(count), 7);
    rst = 1'b1;
    cycle();
    chk("rst1_count", 32'(count), 0);
    chk("rst1_tick", 32'(tick), 0);
    chk("rst1_tc", 32'(tc), 0);
    cycle();
    rst = 1'b0;
    cycle();
    chk("resume", 32'(count), 1);

    // Saturate up.
    rst = 1'b1; cycle(); rst = 1'b0;
    modulo = 8'd3; mode = 1'b1; dir = 1'b0; prescale = '0;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      chk("satup_count", 32'(count), (i < 3) ? i : 3);
      chk("satup_tc", 32'(tc), (i == 3) ? 1 : 0);
      chk("satup_sat", 32'(sat), (i >= 3) ? 1 : 0);
      chk("satup_tick", 32'(tick), 1);
    end

    // Down wrap after a load.
    mode = 1'b0; dir = 1'b1; modulo = 8'd9; load_val = 8'd2; load = 1'b1;
    cycle();
    load = 1'b0;
    chk("dn_load", 32'(count), 2);
    chk("dn_load_tick", 32'(tick), 0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("dn_count", 32'(count), exp_dn[i]);
      chk("dn_tc", 32'(tc), (i == 2) ? 1 : 0);
    end

    // Out-of-range load, up-wrap.
    dir = 1'b0; modulo = 8'd10; load_val = 8'd200; load = 1'b1;
    cycle();
    load = 1'b0;
    chk("oor_load", 32'(count), 200);
    cycle();
    chk("oor_count", 32'(count), 0);
    chk("oor_tc", 32'(tc), 1);

    // Load coinciding with a step.
    modulo = 8'd100; prescale = 16'd2;
    for (int i = 0; i < 10 && m_pcnt != 2; i++) cycle();
    load_val = 8'd50; load = 1'b1;
    cycle();
    load = 1'b0;
    chk("ldstep_count", 32'(count), 50);
    chk("ldstep_tick", 32'(tick), 0);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      chk("ldstep_tick_after", 32'(tick), (i == 3) ? 1 : 0);
    end
    chk("ldstep_next", 32'(count), 51);

    // Enable freeze and capture.
    prescale = '0; modulo = 8'd10; load_val = 8'd4; load = 1'b1;
    cycle();
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("en0_count", 32'(count), 4);
      chk("en0_tick", 32'(tick), 0);
    end
    capture = 1'b1;
    cycle();
    capture = 1'b0;
`ifdef BTC_CAPTURE_EN
    chk("cap_val4", 32'(cap_val), 4);
    chk("cap_valid1", 32'(cap_valid), 1);
`else
    chk("cap_val_tied", 32'(cap_val), 0);
    chk("cap_valid_tied", 32'(cap_valid), 0);
`endif
    load_val = 8'd7; load = 1'b1;
    cycle();
    load = 1'b0;
    chk("cap_clear", 32'(cap_valid), 0);
    en = 1'b1;

    // Randomized traffic; prescale only ever moves to >= the live prescaler value.
    for (int i = 0; i < 4000; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      en       = ($urandom_range(0, 9) != 0);
      load     = ($urandom_range(0, 19) == 0);
      capture  = ($urandom_range(0, 19) == 0);
      load_val = 8'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        dir  = 1'($urandom_range(0, 1));
        mode = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 15) == 0)
        modulo = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      if ($urandom_range(0, 15) == 0)
        prescale = 16'(m_pcnt + int'($urandom_range(0, 3)));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
